// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller.
// Holds the FSM state encoding, the BCD digit maximum and a small helper
// that flags a digit sitting at its maximum value.
package stopwatch_ctrl_pkg;

  // Controller states; the encodings are fixed so that downstream
  // debug tooling can decode a raw state capture.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_FULL  = 2'd3
  } sw_state_e;

  // Largest value a BCD digit may hold.
  localparam logic [3:0] BCD_MAX = 4'd9;

  // True when a digit is at its maximum and would roll over on the next step.
  function automatic logic is_bcd_max(input logic [3:0] q);
    return (q == BCD_MAX);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Control/status bundle between the button front end, the stopwatch
// controller and the display scanner.
//   start, stop, clear : single-cycle command pulses (master -> slave)
//   digits             : BCD value, digit 0 in bits [3:0] (slave -> master)
//   running, overflow  : state flags (slave -> master)
//   tick               : one-cycle strobe after each counted step
interface stopwatch_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic                  stop;
  logic                  clear;
  logic [4*DIGITS-1:0]   digits;
  logic                  running;
  logic                  overflow;
  logic                  tick;

  modport master (
    output start, stop, clear,
    input  digits, running, overflow, tick
  );

  modport slave (
    input  start, stop, clear,
    output digits, running, overflow, tick
  );
endinterface

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One decade of the BCD counter cascade.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to 0 (wins over en)
//   en         : step this digit by one on the next edge
//   q[3:0]     : current digit value, always 0..9
//   rc         : ripple carry, high when a step would roll 9 -> 0
module bcd_digit
  import stopwatch_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] q,
  output logic       rc
);

  // Digit register: clear, step with 9 -> 0 wrap, or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (en) begin
      q <= is_bcd_max(q) ? 4'd0 : (q + 4'd1);
    end else begin
      q <= q;
    end
  end

  // Carry to the next decade.
  assign rc = en & is_bcd_max(q);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear sequencer for a cascade of BCD digit counters.
//   DIGITS   : number of cascaded BCD digits (1..8)
//   TICK_DIV : clk cycles per count step (>= 2)
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : slave side of stopwatch_ctrl_if (commands in, value/status out)
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  stopwatch_ctrl_if.slave   bus
);

  localparam int            PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  sw_state_e        state_r;
  logic             running_r;
  logic             overflow_r;
  logic             tick_r;
  logic [PW-1:0]    presc_r;

  logic             cnt_en_s;
  logic             inc_s;
  logic             sat_s;
  logic             go_s;
  logic             halt_s;

  logic [3:0]        q_s [DIGITS];
  logic [DIGITS-1:0] en_s;
  logic [DIGITS-1:0] rc_s;
  logic [DIGITS-1:0] nine_s;
  logic              carry_out_unused_s;

  // Command decode and count strobes.
  // start together with stop cancels both; clear overrides everything.
  always_comb begin
    go_s     = bus.start & ~bus.stop & ~bus.clear;
    halt_s   = bus.stop & ~bus.start & ~bus.clear;
    cnt_en_s = (state_r == ST_RUN) & ~bus.stop & ~bus.clear;
    inc_s    = cnt_en_s & (presc_r == PRESC_MAX);
    sat_s    = inc_s & (&nine_s);
  end

  // Controller FSM with registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      running_r  <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (go_s) begin
            state_r   <= ST_RUN;
            running_r <= 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.clear) begin
            state_r   <= ST_IDLE;
            running_r <= 1'b0;
          end else if (halt_s) begin
            state_r   <= ST_PAUSE;
            running_r <= 1'b0;
          end else if (sat_s) begin
            state_r    <= ST_FULL;
            running_r  <= 1'b0;
            overflow_r <= 1'b1;
          end
        end
        ST_PAUSE: begin
          if (bus.clear) begin
            state_r <= ST_IDLE;
          end else if (go_s) begin
            state_r   <= ST_RUN;
            running_r <= 1'b1;
          end
        end
        ST_FULL: begin
          if (bus.clear) begin
            state_r    <= ST_IDLE;
            overflow_r <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          running_r  <= 1'b0;
          overflow_r <= 1'b0;
        end
      endcase
    end
  end

  // Prescaler: counts only while enabled, holds otherwise, so a pause
  // resumes with the remaining part of the interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= '0;
    end else if (bus.clear) begin
      presc_r <= '0;
    end else if (cnt_en_s) begin
      presc_r <= (presc_r == PRESC_MAX) ? '0 : (presc_r + PW'(1));
    end else begin
      presc_r <= presc_r;
    end
  end

  // Step strobe, delayed so it lines up with the updated digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_r <= 1'b0;
    end else begin
      tick_r <= inc_s;
    end
  end

  // Digit 0 is gated off at saturation so the value holds at all 9s.
  assign en_s[0] = inc_s & ~sat_s;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    if (gi > 0) begin : g_chain
      assign en_s[gi] = rc_s[gi-1];
    end
    bcd_digit u_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (bus.clear),
      .en    (en_s[gi]),
      .q     (q_s[gi]),
      .rc    (rc_s[gi])
    );
    assign nine_s[gi]           = is_bcd_max(q_s[gi]);
    assign bus.digits[4*gi +: 4] = q_s[gi];
  end

  // The top carry can never fire because digit 0 is gated at saturation.
  assign carry_out_unused_s = rc_s[DIGITS-1];

  assign bus.running  = running_r;
  assign bus.overflow = overflow_r;
  assign bus.tick     = tick_r;

endmodule
